softmax_exp_sum: RTL
====================

Name: softmax_exp_sum

Overview:
- Second pass of the softmax datapath; sits directly downstream of the vector max-reduction stage.
- Takes the vector max, re-streams the same int8 vector, and computes d = max - x for each element.
- Looks up e = 2^(-d / 2^STEP_LOG2) in Q0.16 and streams e out to the normalisation stage.
- Accumulates sum(e) and presents it once per vector.

Parameters:
- STEP_LOG2, 4: input quantisation; d is divided by 2^STEP_LOG2 before the exponent.
- SUM_W, 24: width of the sum accumulator in bits.

Ports:
- clk        in   1      clock
- rst        in   1      synchronous, active-high reset
- start      in   1      pulse; samples max_in and arms the block for one vector
- max_in     in   8      signed int8 vector max from the reduction stage
- din_valid  in   1      input element valid
- din_ready  out  1      block accepts an element on this cycle
- din        in   8      signed int8 element
- din_last   in   1      marks the final element of the vector
- exp_valid  out  1      output element valid
- exp_ready  in   1      downstream accepts the output element
- exp_data   out  16     unsigned Q0.16 exponent value
- exp_last   out  1      output element is the last of the vector
- sum_out    out  SUM_W  unsigned sum of all exp_data in the vector
- sum_valid  out  1      one-cycle pulse; sum_out is final
- busy       out  1      high from start until the sum_valid pulse

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - state=IDLE.
  - All pipeline valids, exp_valid, sum_valid, busy and din_ready are 0.
  - exp_data, sum_out and the max register are 0.
  - Reset mid-vector discards all in-flight data; no sum_valid is produced.
- States:
  - IDLE -> RUN on start: latch max_in; clear the accumulator.
  - RUN -> DRAIN on an input handshake with din_last=1.
  - DRAIN -> DONE when the output handshake with exp_last=1 occurs.
  - DONE -> IDLE after one cycle; sum_valid=1 during DONE.
- busy = (state != IDLE).
- start in any non-IDLE state aborts the current vector:
  - Pipeline valids are cleared.
  - The new max is latched, the accumulator is cleared, and the block goes to RUN.
  - No sum_valid is produced for the aborted vector.
  - start has priority over every other event in the same cycle.
- Pipeline: 2 stages, with a single advance enable adv = !s2_valid || exp_ready.
  - Stage 1 registers: idx = min(max_r - din, 255).
    - Compute in 9-bit signed; a negative result (din > max_r, i.e. a stale or bad max) clamps to 0.
    - Also registers valid and last.
  - Stage 2 registers: exp_data = LUT[idx], exp_last, exp_valid.
  - din_ready = (state == RUN) && adv.
  - The input handshake is din_valid && din_ready.
  - The whole pipeline holds when adv=0; no data is lost or duplicated under backpressure.
  - Latency: 2 cycles from input handshake to exp_valid with exp_ready held high; throughput is 1 element per cycle.
- LUT: 256 entries, constant.
  - LUT[d] = round(65535 * 2^(-d / 2^STEP_LOG2)), clipped to the range [0, 65535].
  - With default STEP_LOG2: LUT[0]=65535, LUT[16]=32768, LUT[32]=16384, LUT[255]=1.
- Accumulator:
  - On every output handshake (exp_valid && exp_ready): sum += exp_data, zero-extended to SUM_W.
  - Overflow behaviour is set by the optional feature.
- sum_out:
  - Holds the accumulator value continuously.
  - Is final in the DONE cycle and stays stable until the next start.
- Vector length:
  - A 1-element vector (din_last on the first element) is legal.
  - din_valid with no preceding start is ignored; din_ready stays 0 in IDLE.

Optional Feature:
- Macro: SOFTMAX_SUM_SAT_EN.
- Defined: the accumulator saturates at 2^SUM_W-1 and holds there for the rest of the vector.
- Undefined: the accumulator wraps modulo 2^SUM_W.

Test Plan:
1. start with max_in=10; stream 4 elements {10, -6, 10, -22}, last on the 4th, exp_ready=1.
   - exp_data = 65535, 32768, 65535, 16384, each 2 cycles after its input.
   - exp_last only on the 4th element.
   - sum_valid one cycle after the 4th output handshake, with sum_out=180222.
2. Same vector with exp_ready toggling 1,0,0,1,...
   - Identical exp_data sequence and sum; the value is held while stalled.
   - din_ready=0 on every cycle where s2 is valid and exp_ready=0.
3. start with max_in=127; stream 3 elements {-128, 127, 0}.
   - First element: idx=255 -> 1; second: 65535.
   - Third: idx=127 -> round(65535 * 2^-7.9375) = 267.
   - sum_out=65803.
4. 257 elements all equal to max_in=5, exp_ready=1.
   - With SOFTMAX_SUM_SAT_EN: sum_out=16777215.
   - Without it: sum_out=(257*65535) mod 2^24 = 65279.
5. Abort: start with max_in=0, feed 3 elements, then start with max_in=-1 while busy; then stream 1 element {-1} with last.
   - No sum_valid for the aborted vector.
   - Output is 65535, sum_out=65535, busy falls after the sum_valid pulse.
6. Assert rst while 2 elements are in the pipeline.
   - The next cycle has exp_valid=0, busy=0, sum_out=0, din_ready=0.
   - din_valid before the next start gets no response.

Source files
------------

// File: rtl/softmax_exp_sum.sv
// softmax_exp_sum: second softmax pass. Computes e = 2^(-(max - x) / 2^STEP_LOG2)
// in Q0.16 for each element of a re-streamed int8 vector, streams e downstream
// and accumulates sum(e), presented once per vector.
// Optional feature macro: SOFTMAX_SUM_SAT_EN (saturating accumulator; default wraps).
module softmax_exp_sum #(
  parameter int STEP_LOG2 = 4,
  parameter int SUM_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] max_in,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic signed [7:0] din,
  input  logic              din_last,
  output logic              exp_valid,
  input  logic              exp_ready,
  output logic [15:0]       exp_data,
  output logic              exp_last,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q;
  logic               busy_q;
  logic               sum_valid_q;
  logic signed [7:0]  max_q;

  logic               vld_p1_q;
  logic [7:0]         idx_p1_q;
  logic               last_p1_q;
  logic               vld_p2_q;
  logic [15:0]        exp_data_q;
  logic               exp_last_q;

  logic [SUM_W-1:0]   sum_q;
  logic [SUM_W-1:0]   sum_d;
  logic [7:0]         idx_d;
  logic               adv;
  logic               in_hs;
  logic               out_hs;

  logic [15:0]        lut [256];

  // LUT entry: round(65535 * 2^(-d / 2^STEP_LOG2)), clipped to 16 bits.
  function automatic int lut_entry(input int d);
    real v;
    v = 65535.0 * (2.0 ** (-real'(d) / real'(2 ** STEP_LOG2))) + 0.5;
    if (v > 65535.0) v = 65535.0;
    if (v < 0.0) v = 0.0;
    return $rtoi(v);
  endfunction

  // Table index: max - x in 9-bit signed; a negative distance means the max
  // was stale or wrong, so treat the element as the max itself.
  function automatic logic [7:0] clamp_idx(input logic signed [7:0] m,
                                           input logic signed [7:0] x);
    logic signed [8:0] d;
    d = $signed({m[7], m}) - $signed({x[7], x});
    if (d < 0) return 8'd0;
    return d[7:0];
  endfunction

  // Accumulator add with one guard bit to detect overflow.
  function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] a,
                                               input logic [15:0]      b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W-15){1'b0}}, b};
`ifdef SOFTMAX_SUM_SAT_EN
    if (s[SUM_W]) return '1;
`endif
    return s[SUM_W-1:0];
  endfunction

  for (genvar g = 0; g < 256; g++) begin : g_lut
    assign lut[g] = 16'(lut_entry(g));
  end

  // Handshakes and the single pipeline advance enable.
  always_comb begin
    adv       = !vld_p2_q || exp_ready;
    din_ready = (state_q == S_RUN) && adv;
    in_hs     = din_valid && din_ready;
    out_hs    = vld_p2_q && exp_ready;
    idx_d     = clamp_idx(max_q, din);
    sum_d     = acc_add(sum_q, exp_data_q);
  end

  // Vector sequencing FSM; start aborts and re-arms from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      max_q       <= '0;
    end else if (start) begin
      state_q     <= S_RUN;
      busy_q      <= 1'b1;
      sum_valid_q <= 1'b0;
      max_q       <= max_in;
    end else begin
      sum_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          if (in_hs && din_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_hs && exp_last_q) begin
            state_q     <= S_DONE;
            sum_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stage 1 data: table index and last flag, captured on input handshake.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      idx_p1_q  <= idx_d;
      last_p1_q <= din_last;
    end
  end

  // Stage 1 -> stage 2: valids shift on adv; stage 2 holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      exp_data_q <= '0;
      exp_last_q <= 1'b0;
    end else if (start) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= in_hs;
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        exp_data_q <= lut[idx_p1_q];
        exp_last_q <= last_p1_q;
      end
    end
  end

  // Sum of every exponent accepted downstream.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sum_q <= '0;
    end else if (out_hs) begin
      sum_q <= sum_d;
    end
  end

  assign exp_valid = vld_p2_q;
  assign exp_data  = exp_data_q;
  assign exp_last  = exp_last_q;
  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = busy_q;

endmodule
